// File: rtl/seq_checker_mod3.sv
// seq_checker_mod3: lock detector for a 2-bit mod-3 counter stream (00->01->10->00)
// Ports:
//   Clk     - rising-edge clock
//   Rst     - asynchronous active-low reset
//   valid   - qualifies din; all state holds when low
//   din     - received counter sample (11 is illegal)
//   locked  - high while in LOCKED
//   err     - one-cycle pulse per mismatching sample seen while LOCKED
//   wraps   - count of correct 10->00 transitions seen while LOCKED, modulo 256
//   err_cnt - saturating count of err pulses
// Macro SEQ_CHK_ERRCNT_EN enables the err_cnt counter; otherwise err_cnt is tied to 0.
module seq_checker_mod3 #(
    parameter int LOCK_N   = 3,
    parameter int UNLOCK_N = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       valid,
    input  logic [1:0] din,
    output logic       locked,
    output logic       err,
    output logic [7:0] wraps,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
    localparam logic [2:0] LOCK_V   = 3'(LOCK_N);
    localparam logic [2:0] UNLOCK_V = 3'(UNLOCK_N);
    state_t     state, state_n;
    logic [1:0] prev, prev_n, exp_din;
    logic [2:0] good, good_n, bad, bad_n;
    logic [7:0] wraps_n;
    logic       err_n, match;
    // prev only ever holds a legal code, so exp_din is never 11 and a match implies din is legal
    assign exp_din = (prev == 2'b10) ? 2'b00 : prev + 2'b01;
    assign match   = (din == exp_din);
    always_comb begin
        state_n = state;
        prev_n  = prev;
        good_n  = good;
        bad_n   = bad;
        wraps_n = wraps;
        err_n   = 1'b0;
        if (valid) begin
            // every legal sample becomes the new reference, matched or not
            if (din != 2'b11)
                prev_n = din;
            case (state)
                HUNT: begin
                    if (din != 2'b11) begin
                        good_n  = 3'd0;
                        state_n = SYNC;
                    end
                end
                SYNC: begin
                    if (din == 2'b11)
                        state_n = HUNT;
                    else if (match) begin
                        good_n = good + 3'd1;
                        if (good_n == LOCK_V) begin
                            state_n = LOCKED;
                            bad_n   = 3'd0;
                        end
                    end else
                        good_n = 3'd0;
                end
                LOCKED: begin
                    if (match) begin
                        bad_n = 3'd0;
                        if (prev == 2'b10)
                            wraps_n = wraps + 8'd1;
                    end else begin
                        err_n = 1'b1;
                        bad_n = bad + 3'd1;
                        if (bad_n == UNLOCK_V)
                            state_n = HUNT;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= HUNT;
            prev   <= 2'b00;
            good   <= 3'd0;
            bad    <= 3'd0;
            locked <= 1'b0;
            err    <= 1'b0;
            wraps  <= 8'd0;
        end else begin
            state  <= state_n;
            prev   <= prev_n;
            good   <= good_n;
            bad    <= bad_n;
            locked <= (state_n == LOCKED);
            err    <= err_n;
            wraps  <= wraps_n;
        end
    end
`ifdef SEQ_CHK_ERRCNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            err_cnt <= 8'd0;
        else if (err_n && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'h00;
`endif
endmodule
